tft_spi_decoder: RTL and testbench
==================================

TFT_SPI_DECODER -- requirements
Module: tft_spi_decoder

Interface
REQ-001 SHALL have clk_in  input  1  system clock, 100 MHz.
REQ-002 SHALL have rst_in  input  1  reset, synchronous, active-high.
REQ-003 SHALL have tft_sck  input  1  SPI clock from the display driver; mode 0, data sampled on rising edge.
REQ-004 SHALL have tft_sdi  input  1  SPI data, MSB first.
REQ-005 SHALL have tft_dc  input  1  0 = command byte, 1 = data/parameter byte.
REQ-006 SHALL have tft_cs  input  1  chip select, active-low.
REQ-007 SHALL have tft_reset  input  1  panel reset, active-low.
REQ-008 SHALL have cmd_valid  output  1  one-cycle pulse per received command byte.
REQ-009 SHALL have cmd_byte  output  8  last received command opcode.
REQ-010 SHALL have pix_valid  output  1  one-cycle pulse per completed pixel write.
REQ-011 SHALL have pix_col  output  8  column of the written pixel, low 8 bits of the column counter.
REQ-012 SHALL have pix_row  output  9  row of the written pixel, low 9 bits of the row counter.
REQ-013 SHALL have pix_data  output  16  RGB565 pixel value.

Function
REQ-014 SHALL pass tft_sck, tft_sdi, tft_dc, tft_cs and tft_reset through 2-FF synchronizers, then detect sck rising edges on the synchronized signal; the sck high and low phases are each at least 2 clk_in cycles.
REQ-015 SHALL shift tft_sdi in on each sck rising edge while tft_cs is low, and capture tft_dc with bit 7 (the last bit); 8 bits form one byte.
REQ-016 SHALL clear the bit counter and discard any partial byte while tft_cs is high; completed bytes are unaffected.
REQ-017 SHALL fix latency at 4 clk_in cycles from the pin-level sck edge of the final bit to the cmd_valid or pix_valid pulse.
REQ-018 SHALL use decode FSM states IDLE, CASET, PASET, RAMWR, SKIP.
REQ-019 SHALL, on any dc=0 byte in any state: pulse cmd_valid, load cmd_byte, clear the pixel-half flag, and enter CASET (0x2A), PASET (0x2B) or RAMWR (0x2C); any other opcode enters SKIP.
REQ-020 SHALL ignore dc=1 bytes in IDLE and SKIP.
REQ-021 SHALL, in CASET, collect 4 parameter bytes as XS[15:8], XS[7:0], XE[15:8], XE[7:0], then go to IDLE; PASET does the same for YS/YE.
REQ-022 SHALL, on entering RAMWR, load col_cnt=XS and row_cnt=YS.
REQ-023 SHALL, in RAMWR, treat byte pairs as high byte then low byte; on the low byte, pulse pix_valid with the current counters and data, then advance col_cnt.
REQ-024 SHALL advance the counters as follows: col_cnt==XE wraps col_cnt to XS and increments row_cnt; row_cnt==YE on that wrap wraps row_cnt to YS.
REQ-025 SHALL keep window registers and counters 16 bits wide; XS>XE or YS>YE is legal and produces a window of XS..0xFFFF wrapped only on equality (no clamping).
REQ-026 SHALL discard a pending high byte when a new command arrives; the pixel-half flag persists across tft_cs high.
REQ-027 SHALL hold cmd_byte and pix_* between pulses.

Reset
REQ-028 SHALL, on rst_in=1 or synchronized tft_reset=0, set state=IDLE, bit counter=0, pixel-half=0, cmd_valid=0, pix_valid=0, cmd_byte=0x00, pix_col=0, pix_row=0, pix_data=0, XS=0, XE=239, YS=0, YE=319.
REQ-029 SHALL allow reset mid-byte or mid-pixel to abandon all partial state with no pulse emitted.

Structure
REQ-030 SHALL define in shared package tft_pkg: opcode constants (0x2A, 0x2B, 0x2C), the state enum, default window (239, 319) and screen dimensions.
REQ-031 SHALL isolate synchronizers, edge detect and the shifter in sub-module spi_byte_rx, which outputs byte_valid, byte, and is_data.

Verification
REQ-032 SHALL cover: reset, then bytes 0x2C(dc0), 0xF8(dc1), 0x00(dc1) -> cmd_valid with cmd_byte=0x2C; pix_valid once with col 0, row 0, data 0xF800.
REQ-033 SHALL cover: CASET 0x0064..0x0096 and PASET 0x00C8..0x00FA, RAMWR, 2 pixels -> pix (100,200), then (101,200).
REQ-034 SHALL cover: CASET 5..6, PASET 10..11, RAMWR, 5 pixels -> (5,10), (6,10), (5,11), (6,11), (5,10).
REQ-035 SHALL cover: tft_cs raised after 5 bits, then a full byte 0x2C -> exactly one cmd_valid, cmd_byte=0x2C.
REQ-036 SHALL cover: RAMWR then high byte 0xAB, then command 0x00, then RAMWR then 0x12, 0x34 -> one pix_valid with data 0x1234.
REQ-037 SHALL cover: rst_in pulsed mid-pixel -> no pix_valid; a following RAMWR writes start at (0,0).

Source files
------------

// File: rtl/tft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tft_pkg
// Description : Shared definitions for the TFT SPI command/pixel decoder:
//               controller opcodes, decode state type, default address window
//               and panel dimensions.
// Revision    : 1.0 - initial release
// ============================================================================
package tft_pkg;

    // Panel geometry (portrait 240 x 320)
    localparam int c_SCREEN_W = 240;
    localparam int c_SCREEN_H = 320;

    // Window that is active after reset: the full panel
    localparam logic [15:0] c_DEF_XE = 16'(c_SCREEN_W - 1);  // 239
    localparam logic [15:0] c_DEF_YE = 16'(c_SCREEN_H - 1);  // 319

    // Controller opcodes that the decoder acts on
    localparam logic [7:0] c_OP_CASET = 8'h2A;
    localparam logic [7:0] c_OP_PASET = 8'h2B;
    localparam logic [7:0] c_OP_RAMWR = 8'h2C;

    // Decode state, explicitly encoded
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CASET = 3'd1,
        S_PASET = 3'd2,
        S_RAMWR = 3'd3,
        S_SKIP  = 3'd4
    } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_byte_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_rx
// Description : Brings the SPI pins into the clk_in domain (2-FF sync),
//               detects sck rising edges and assembles MSB-first bytes.
//               The dc pin is captured together with the last bit.
// Ports       : clk_in, rst_in        - system clock / sync active-high reset
//               tft_sck/sdi/dc/cs     - raw SPI pins (mode 0, cs active-low)
//               tft_reset             - raw panel reset pin, active-low
//               byte_valid            - one-cycle strobe, byte_data complete
//               byte_data, is_data    - received byte and its dc level
//               panel_rst             - synchronized panel reset, active-high
// Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_rx (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       tft_sck,
    input  logic       tft_sdi,
    input  logic       tft_dc,
    input  logic       tft_cs,
    input  logic       tft_reset,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       is_data,
    output logic       panel_rst
);

    // Stage [0] is the metastability catcher, stage [1] is the usable value
    logic [1:0] r_sck_sync;
    logic [1:0] r_sdi_sync;
    logic [1:0] r_dc_sync;
    logic [1:0] r_cs_sync;
    logic [1:0] r_rst_n_sync;
    logic       r_sck_prev;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;

    logic       w_sck_rise;

    // Synchronizers are cleared only by rst_in: the panel-reset chain must
    // not be reset by its own output.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sck_sync   <= 2'b00;
            r_sdi_sync   <= 2'b00;
            r_dc_sync    <= 2'b00;
            r_cs_sync    <= 2'b11;
            r_rst_n_sync <= 2'b11;
            r_sck_prev   <= 1'b0;
        end else begin
            r_sck_sync   <= {r_sck_sync[0],   tft_sck};
            r_sdi_sync   <= {r_sdi_sync[0],   tft_sdi};
            r_dc_sync    <= {r_dc_sync[0],    tft_dc};
            r_cs_sync    <= {r_cs_sync[0],    tft_cs};
            r_rst_n_sync <= {r_rst_n_sync[0], tft_reset};
            r_sck_prev   <= r_sck_sync[1];
        end
    end

    assign w_sck_rise = r_sck_sync[1] & ~r_sck_prev;
    assign panel_rst  = ~r_rst_n_sync[1];

    always_ff @(posedge clk_in) begin
        if (rst_in || panel_rst) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            is_data    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (r_cs_sync[1]) begin
                // Deselected: any partial byte is dropped
                r_bit_cnt <= 3'd0;
            end else if (w_sck_rise) begin
                r_shift   <= {r_shift[5:0], r_sdi_sync[1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {r_shift, r_sdi_sync[1]};
                    is_data    <= r_dc_sync[1];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tft_spi_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tft_spi_decoder
// Description : Snoops the SPI link of an ILI9341-style TFT controller and
//               decodes CASET/PASET/RAMWR traffic into pixel writes with
//               column/row coordinates.
// Ports       : clk_in, rst_in        - 100 MHz clock / sync active-high reset
//               tft_*                 - raw SPI and panel-reset pins
//               cmd_valid, cmd_byte   - command strobe and last opcode
//               pix_valid             - strobe per completed RGB565 pixel
//               pix_col, pix_row      - low bits of the column/row counters
//               pix_data              - RGB565 value
// Revision    : 1.0 - initial release
// ============================================================================
module tft_spi_decoder
    import tft_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        tft_sck,
    input  logic        tft_sdi,
    input  logic        tft_dc,
    input  logic        tft_cs,
    input  logic        tft_reset,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        pix_valid,
    output logic [7:0]  pix_col,
    output logic [8:0]  pix_row,
    output logic [15:0] pix_data
);

    logic       w_byte_valid;
    logic [7:0] w_byte;
    logic       w_is_data;
    logic       w_panel_rst;
    logic       w_rst;

    dec_state_t  r_state;
    logic        r_half;      // high byte of a pixel is pending
    logic [7:0]  r_hi;
    logic [1:0]  r_pidx;      // parameter byte index inside CASET/PASET
    logic [15:0] r_xs;
    logic [15:0] r_xe;
    logic [15:0] r_ys;
    logic [15:0] r_ye;
    logic [15:0] r_col;
    logic [15:0] r_row;

    spi_byte_rx u_rx (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .tft_sck    (tft_sck),
        .tft_sdi    (tft_sdi),
        .tft_dc     (tft_dc),
        .tft_cs     (tft_cs),
        .tft_reset  (tft_reset),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte),
        .is_data    (w_is_data),
        .panel_rst  (w_panel_rst)
    );

    assign w_rst = rst_in | w_panel_rst;

    always_ff @(posedge clk_in) begin
        if (w_rst) begin
            r_state   <= S_IDLE;
            r_half    <= 1'b0;
            r_hi      <= 8'h00;
            r_pidx    <= 2'd0;
            r_xs      <= 16'd0;
            r_xe      <= c_DEF_XE;
            r_ys      <= 16'd0;
            r_ye      <= c_DEF_YE;
            r_col     <= 16'd0;
            r_row     <= 16'd0;
            cmd_valid <= 1'b0;
            cmd_byte  <= 8'h00;
            pix_valid <= 1'b0;
            pix_col   <= 8'h00;
            pix_row   <= 9'h000;
            pix_data  <= 16'h0000;
        end else begin
            cmd_valid <= 1'b0;
            pix_valid <= 1'b0;
            if (w_byte_valid) begin
                if (!w_is_data) begin
                    // A command always wins, whatever state we are in
                    cmd_valid <= 1'b1;
                    cmd_byte  <= w_byte;
                    r_half    <= 1'b0;
                    r_pidx    <= 2'd0;
                    case (w_byte)
                        c_OP_CASET: r_state <= S_CASET;
                        c_OP_PASET: r_state <= S_PASET;
                        c_OP_RAMWR: begin
                            r_state <= S_RAMWR;
                            r_col   <= r_xs;
                            r_row   <= r_ys;
                        end
                        default:    r_state <= S_SKIP;
                    endcase
                end else begin
                    case (r_state)
                        S_CASET: begin
                            case (r_pidx)
                                2'd0: r_xs[15:8] <= w_byte;
                                2'd1: r_xs[7:0]  <= w_byte;
                                2'd2: r_xe[15:8] <= w_byte;
                                2'd3: r_xe[7:0]  <= w_byte;
                            endcase
                            r_pidx <= r_pidx + 2'd1;
                            if (r_pidx == 2'd3) r_state <= S_IDLE;
                        end
                        S_PASET: begin
                            case (r_pidx)
                                2'd0: r_ys[15:8] <= w_byte;
                                2'd1: r_ys[7:0]  <= w_byte;
                                2'd2: r_ye[15:8] <= w_byte;
                                2'd3: r_ye[7:0]  <= w_byte;
                            endcase
                            r_pidx <= r_pidx + 2'd1;
                            if (r_pidx == 2'd3) r_state <= S_IDLE;
                        end
                        S_RAMWR: begin
                            if (!r_half) begin
                                r_hi   <= w_byte;
                                r_half <= 1'b1;
                            end else begin
                                pix_valid <= 1'b1;
                                pix_col   <= r_col[7:0];
                                pix_row   <= r_row[8:0];
                                pix_data  <= {r_hi, w_byte};
                                r_half    <= 1'b0;
                                // Wrap only on equality; an inverted window
                                // runs through 0xFFFF -> 0 naturally.
                                if (r_col == r_xe) begin
                                    r_col <= r_xs;
                                    r_row <= (r_row == r_ye) ? r_ys : r_row + 16'd1;
                                end else begin
                                    r_col <= r_col + 16'd1;
                                end
                            end
                        end
                        default: ;  // IDLE / SKIP ignore parameter bytes
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tft_spi_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tft_spi_decoder
// Description : Self-checking bench for tft_spi_decoder: directed byte
//               tables, multi-cycle corner sequences and a randomized byte
//               stream compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tft_spi_decoder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        tft_sck = 1'b0;
    logic        tft_sdi = 1'b0;
    logic        tft_dc = 1'b0;
    logic        tft_cs = 1'b1;
    logic        tft_reset = 1'b1;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        pix_valid;
    logic [7:0]  pix_col;
    logic [8:0]  pix_row;
    logic [15:0] pix_data;

    int checks = 0;
    int failures = 0;

    tft_spi_decoder dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .tft_sck   (tft_sck),
        .tft_sdi   (tft_sdi),
        .tft_dc    (tft_dc),
        .tft_cs    (tft_cs),
        .tft_reset (tft_reset),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .pix_valid (pix_valid),
        .pix_col   (pix_col),
        .pix_row   (pix_row),
        .pix_data  (pix_data)
    );

    always #5 clk_in = ~clk_in;

    // Observed pulses, collected on the falling edge
    logic [7:0]  act_cmd[$];
    logic [32:0] act_pix[$];   // {col, row, data}

    always @(negedge clk_in) begin
        if (cmd_valid) act_cmd.push_back(cmd_byte);
        if (pix_valid) act_pix.push_back({pix_col, pix_row, pix_data});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // MSB-first bits; each sck phase lasts 3 clk_in cycles
    task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            tft_sdi = b[7-i];
            tft_dc  = dc;
            tft_sck = 1'b0;
            tick(3);
            tft_sck = 1'b1;
            tick(3);
        end
        tft_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        tft_cs = 1'b0;
        send_bits(b, dc, 8);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick(3);
        rst_in = 1'b0;
        tick(3);
    endtask

    // ---------------- directed byte table ----------------
    typedef struct {
        logic        dc;
        logic [7:0]  b;
        int          ecmd;
        logic [7:0]  cb;
        int          epix;
        logic [7:0]  col;
        logic [8:0]  row;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[$];

    task automatic v_cmd(input logic [7:0] b);
        vec_t v;
        v = '{1'b0, b, 1, b, 0, 8'h0, 9'h0, 16'h0};
        vecs.push_back(v);
    endtask

    task automatic v_dat(input logic [7:0] b);
        vec_t v;
        v = '{1'b1, b, 0, 8'h0, 0, 8'h0, 9'h0, 16'h0};
        vecs.push_back(v);
    endtask

    task automatic v_pix(input logic [7:0] b, input int col, input int row, input logic [15:0] d);
        vec_t v;
        v = '{1'b1, b, 0, 8'h0, 1, col[7:0], row[8:0], d};
        vecs.push_back(v);
    endtask

    // ---------------- behavioural reference model ----------------
    // mode: 0 idle, 1 loading column window, 2 loading row window,
    //       3 writing pixels, 4 ignoring parameters
    int          m_mode, m_idx, m_xs, m_xe, m_ys, m_ye, m_col, m_row, m_hi;
    bit          m_half;
    logic [7:0]  exp_cmd[$];
    logic [32:0] exp_pix[$];

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_half = 0; m_hi = 0;
        m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
        m_col = 0; m_row = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic dc);
        logic [32:0] p;
        if (!dc) begin
            exp_cmd.push_back(b);
            m_half = 0;
            m_idx  = 0;
            if (b == 8'h2A)      m_mode = 1;
            else if (b == 8'h2B) m_mode = 2;
            else if (b == 8'h2C) begin m_mode = 3; m_col = m_xs; m_row = m_ys; end
            else                 m_mode = 4;
        end else if (m_mode == 1 || m_mode == 2) begin
            // byte k of the 4-byte parameter list: start hi/lo, end hi/lo
            if (m_mode == 1) begin
                if (m_idx == 0) m_xs = b * 256 + m_xs % 256;
                if (m_idx == 1) m_xs = (m_xs / 256) * 256 + b;
                if (m_idx == 2) m_xe = b * 256 + m_xe % 256;
                if (m_idx == 3) m_xe = (m_xe / 256) * 256 + b;
            end else begin
                if (m_idx == 0) m_ys = b * 256 + m_ys % 256;
                if (m_idx == 1) m_ys = (m_ys / 256) * 256 + b;
                if (m_idx == 2) m_ye = b * 256 + m_ye % 256;
                if (m_idx == 3) m_ye = (m_ye / 256) * 256 + b;
            end
            m_idx++;
            if (m_idx == 4) m_mode = 0;
        end else if (m_mode == 3) begin
            if (!m_half) begin
                m_hi = b;
                m_half = 1;
            end else begin
                p = {m_col[7:0], m_row[8:0], m_hi[7:0], b};
                exp_pix.push_back(p);
                m_half = 0;
                if (m_col == m_xe) begin
                    m_col = m_xs;
                    m_row = (m_row == m_ye) ? m_ys : (m_row + 1) % 65536;
                end else begin
                    m_col = (m_col + 1) % 65536;
                end
            end
        end
    endtask

    function automatic logic [7:0] pick_data();
        logic [7:0] r;
        r = 8'($urandom);
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h02;
            3: return 8'hFF;
            4: return 8'hFE;
            5: return 8'hFD;
            default: return r;
        endcase
    endfunction

    int nc0, np0;
    logic [7:0] rb;
    logic       rdc;

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_cmd_byte", cmd_byte, 8'h00);
        chk("rst_pix_col", pix_col, 0);
        chk("rst_pix_row", pix_row, 0);
        chk("rst_pix_data", pix_data, 0);

        // ---------------- table ----------------
        v_cmd(8'h2C); v_dat(8'hF8); v_pix(8'h00, 0, 0, 16'hF800);
        v_cmd(8'h2A); v_dat(8'h00); v_dat(8'h64); v_dat(8'h00); v_dat(8'h96);
        v_cmd(8'h2B); v_dat(8'h00); v_dat(8'hC8); v_dat(8'h00); v_dat(8'hFA);
        v_cmd(8'h2C);
        v_dat(8'hAA); v_pix(8'hBB, 100, 200, 16'hAABB);
        v_dat(8'hCC); v_pix(8'hDD, 101, 200, 16'hCCDD);
        v_cmd(8'h2A); v_dat(8'h00); v_dat(8'h05); v_dat(8'h00); v_dat(8'h06);
        v_cmd(8'h2B); v_dat(8'h00); v_dat(8'h0A); v_dat(8'h00); v_dat(8'h0B);
        v_cmd(8'h2C);
        v_dat(8'h11); v_pix(8'h21, 5, 10, 16'h1121);
        v_dat(8'h12); v_pix(8'h22, 6, 10, 16'h1222);
        v_dat(8'h13); v_pix(8'h23, 5, 11, 16'h1323);
        v_dat(8'h14); v_pix(8'h24, 6, 11, 16'h1424);
        v_dat(8'h15); v_pix(8'h25, 5, 10, 16'h1525);

        for (int i = 0; i < vecs.size(); i++) begin
            nc0 = act_cmd.size();
            np0 = act_pix.size();
            send_byte(vecs[i].b, vecs[i].dc);
            tick(3);
            chk("vec_cmd_count", act_cmd.size() - nc0, vecs[i].ecmd);
            if (vecs[i].ecmd == 1 && act_cmd.size() > nc0)
                chk("vec_cmd_byte", act_cmd[nc0], vecs[i].cb);
            chk("vec_pix_count", act_pix.size() - np0, vecs[i].epix);
            if (vecs[i].epix == 1 && act_pix.size() > np0)
                chk("vec_pix", act_pix[np0], {vecs[i].col, vecs[i].row, vecs[i].data});
        end
        chk("held_cmd_byte", cmd_byte, 8'h2C);
        chk("held_pix_data", pix_data, 16'h1525);

        // ---------------- latency: pin edge of bit 7 to pulse ----------------
        tft_cs = 1'b0;
        send_bits(8'h00, 1'b0, 7);
        tft_sdi = 1'b0;
        tft_sck = 1'b0;
        tick(3);
        tft_sck = 1'b1;
        tick(3);
        chk("latency_early", cmd_valid, 0);
        tick(1);
        chk("latency_at4", cmd_valid, 1);
        tick(1);
        chk("pulse_width", cmd_valid, 0);
        tft_sck = 1'b0;
        tick(3);

        // ---------------- partial byte dropped by cs ----------------
        nc0 = act_cmd.size();
        tft_cs = 1'b0;
        send_bits(8'hFF, 1'b0, 5);
        tft_cs = 1'b1;
        tick(6);
        send_byte(8'h2C, 1'b0);
        tick(4);
        chk("cs_abort_cmd_count", act_cmd.size() - nc0, 1);
        chk("cs_abort_cmd_byte", cmd_byte, 8'h2C);

        // ---------------- pending high byte dropped by a command ----------------
        np0 = act_pix.size();
        send_byte(8'hAB, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h2C, 1'b0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        tick(4);
        chk("drop_hi_pix_count", act_pix.size() - np0, 1);
        chk("drop_hi_pix", {pix_col, pix_row, pix_data}, {8'd5, 9'd10, 16'h1234});

        // ---------------- rst_in mid-pixel ----------------
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h04, 1'b1);
        send_byte(8'h2C, 1'b0);
        np0 = act_pix.size();
        send_byte(8'h55, 1'b1);
        send_bits(8'h66, 1'b1, 4);
        rst_in = 1'b1;
        tick(2);
        rst_in = 1'b0;
        tft_cs = 1'b1;
        tick(8);
        chk("mid_rst_no_pix", act_pix.size() - np0, 0);
        chk("mid_rst_cmd_byte", cmd_byte, 8'h00);
        send_byte(8'h2C, 1'b0);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        tick(4);
        chk("mid_rst_pix_count", act_pix.size() - np0, 1);
        chk("mid_rst_pix", {pix_col, pix_row, pix_data}, {8'd0, 9'd0, 16'h7788});

        // ---------------- panel reset pin restores default window ----------------
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h09, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1);
        tft_reset = 1'b0;
        tick(5);
        tft_reset = 1'b1;
        tick(5);
        np0 = act_pix.size();
        send_byte(8'h2C, 1'b0);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        tick(4);
        chk("panel_rst_pix_count", act_pix.size() - np0, 2);
        if (act_pix.size() - np0 == 2) begin
            chk("panel_rst_pix0", act_pix[np0],     {8'd0, 9'd0, 16'h0102});
            chk("panel_rst_pix1", act_pix[np0 + 1], {8'd1, 9'd0, 16'h0304});
        end

        // ---------------- randomized stream vs model ----------------
        tft_cs = 1'b1;
        do_reset();
        act_cmd.delete();
        act_pix.delete();
        model_reset();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                // abandoned partial byte
                tft_cs = 1'b0;
                send_bits(8'($urandom), 1'($urandom), $urandom_range(1, 7));
                tft_cs = 1'b1;
                tick(4);
            end
            if ($urandom_range(0, 5) == 0) begin
                rdc = 1'b0;
                case ($urandom_range(0, 4))
                    0: rb = 8'h2A;
                    1: rb = 8'h2B;
                    2, 3: rb = 8'h2C;
                    default: rb = 8'($urandom);
                endcase
            end else begin
                rdc = 1'b1;
                rb  = pick_data();
            end
            model_byte(rb, rdc);
            send_byte(rb, rdc);
            if ($urandom_range(0, 7) == 0) begin
                tft_cs = 1'b1;
                tick(4);
            end
        end
        tick(10);
        chk("rand_cmd_count", act_cmd.size(), exp_cmd.size());
        chk("rand_pix_count", act_pix.size(), exp_pix.size());
        for (int i = 0; i < exp_cmd.size() && i < act_cmd.size(); i++)
            chk("rand_cmd", act_cmd[i], exp_cmd[i]);
        for (int i = 0; i < exp_pix.size() && i < act_pix.size(); i++)
            chk("rand_pix", act_pix[i], exp_pix[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
